// File: rtl/mem_pkg.sv
// Shared definitions for the CPU request sequencer and the memory controller:
// state encoding, RW encoding and default bus widths.
package mem_pkg;

    localparam int MEM_DWIDTH = 32;
    localparam int MEM_AWIDTH = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4
    } mem_state_e;

    // Write data sits on the shared bus from issue until Ready returns.
    function automatic logic drives_bus(input mem_state_e st, input logic rw);
        return (rw == RW_WRITE) &&
               ((st == ST_ISSUE) || (st == ST_WAIT_LO) || (st == ST_WAIT_HI));
    endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// CPU-facing request/response bundle of the memory request queue.
// master = CPU side, slave = queue side.
interface mem_req_queue_if #(
    parameter int DWIDTH = mem_pkg::MEM_DWIDTH,
    parameter int AWIDTH = mem_pkg::MEM_AWIDTH
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_rw;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rw, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rw, rsp_rdata, busy
    );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, head visible combinationally; push ignored when full,
// pop ignored when empty. Pointers carry one extra wrap bit to tell full from empty.
module mem_req_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("mem_req_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// Queues CPU loads/stores and issues them one at a time to MemControl (push->rsp_valid 7 cycles
// with a 4-cycle controller); req_ready = !full. MEM_REQ_QUEUE_TIMEOUT_EN adds a watchdog + timeout_err.
module mem_req_queue
    import mem_pkg::*;
#(
    parameter int DWIDTH  = MEM_DWIDTH,
    parameter int AWIDTH  = MEM_AWIDTH,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_req_queue_if.slave    cpu,
    output logic              mc_valid,
    output logic              mc_rw,
    output logic [AWIDTH-1:0] mc_addr,
    inout  wire  [DWIDTH-1:0] mc_data,
    input  logic              mc_ready
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    localparam int EW = 1 + AWIDTH + DWIDTH;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_req_queue: TIMEOUT must be at least 2");
    end

    logic              fifo_full, fifo_empty, pop;
    logic [EW-1:0]     push_dat, head;

    mem_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              terr_q, terr_d;
    logic              expired;

    assign expired     = (cnt_q >= CW'(TIMEOUT - 1));
    assign timeout_err = terr_q;
`endif

    assign push_dat = {cpu.req_rw, cpu.req_addr, cpu.req_wdata};

    mem_req_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (cpu.req_valid && !fifo_full),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            // DONE chains straight into the next issue to keep one request per round trip.
            ST_IDLE, ST_DONE: begin
                if (!fifo_empty) begin
                    state_d                 = ST_ISSUE;
                    pop                     = 1'b1;
                    {rw_d, addr_d, wdata_d} = head;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
                    cnt_d                   = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // An unknown Ready must not be taken as the controller having accepted.
                if (mc_ready == 1'b0) begin
                    state_d = ST_WAIT_HI;
                end
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
                else if (expired) begin
                    state_d = ST_DONE;
                    terr_d  = 1'b1;
                end
                if (!expired) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_WAIT_HI: begin
                if (mc_ready == 1'b1) begin
                    state_d = ST_DONE;
                    if (rw_q == RW_READ) begin
                        rdata_d = mc_data;
                    end
                end
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
                else if (expired) begin
                    state_d = ST_DONE;
                    terr_d  = 1'b1;
                end
                if (!expired) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end
`endif

    // Valid only in ISSUE so the controller never re-triggers on a stale strobe.
    assign mc_valid = (state_q == ST_ISSUE);
    assign mc_rw    = rw_q;
    assign mc_addr  = addr_q;
    assign mc_data  = drives_bus(state_q, rw_q) ? wdata_q : {DWIDTH{1'bz}};

    assign cpu.req_ready = !fifo_full;
    assign cpu.rsp_valid = (state_q == ST_DONE);
    assign cpu.rsp_rw    = (state_q == ST_DONE) ? rw_q : 1'b0;
    assign cpu.rsp_rdata = rdata_q;
    assign cpu.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue against a small MemControl model (Ready drops for busy_len cycles
// after Valid is sampled; reads drive the bus from an internal RAM).
module tb_mem_req_queue;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_req_queue_if #(.DWIDTH(DW), .AWIDTH(AW)) cpu_if ();

    logic          mc_valid, mc_rw, mc_ready;
    logic [AW-1:0] mc_addr;
    wire  [DW-1:0] mc_data;
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
    logic          timeout_err;
`endif

    mem_req_queue #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(4), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu_if),
        .mc_valid (mc_valid),
        .mc_rw    (mc_rw),
        .mc_addr  (mc_addr),
        .mc_data  (mc_data),
        .mc_ready (mc_ready)
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- controller model ----------------
    int            busy_len = 4;
    logic          mc_hold  = 1'b0;
    int            bcnt;
    logic          drv;
    logic [DW-1:0] drv_dat;
    logic [DW-1:0] ram [256];
    logic [AW-1:0] log_addr [64];
    int            log_n = 0;

    assign mc_data = drv ? drv_dat : {DW{1'bz}};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_ready <= 1'b1;
            bcnt     <= 0;
            drv      <= 1'b0;
            drv_dat  <= '0;
        end else if (mc_hold) begin
            mc_ready <= 1'b1;
        end else if (bcnt == 0 && mc_valid) begin
            mc_ready <= 1'b0;
            bcnt     <= busy_len;
            if (log_n < 64) log_addr[log_n] <= mc_addr;
            log_n    <= log_n + 1;
            if (mc_rw) begin
                drv     <= 1'b1;
                drv_dat <= ram[mc_addr[7:0]];
            end else begin
                ram[mc_addr[7:0]] <= mc_data;
            end
        end else if (bcnt == 1) begin
            mc_ready <= 1'b1;
            bcnt     <= 0;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else begin
            drv <= 1'b0;
        end
    end

    // ---------------- response monitor ----------------
    int cyc = 0;
    int rsp_n = 0;
    int rsp_cyc [64];
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cpu_if.rsp_valid) begin
            if (rsp_n < 64) rsp_cyc[rsp_n] = cyc;
            rsp_n++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int w;
        w = 0;
        cpu_if.req_valid = 1'b1;
        cpu_if.req_rw    = rw;
        cpu_if.req_addr  = a;
        cpu_if.req_wdata = d;
        while (!cpu_if.req_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) bound_fail("push_wait");
        tick();
        cpu_if.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (cpu_if.rsp_valid) return;
        end
        bound_fail("rsp_wait");
    endtask

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [10];
        int   n, rb, lb;

        vecs[0] = '{RW_WRITE, 16'h0001, 32'h1111_00A1, 32'hDEAD_BEEF};
        vecs[1] = '{RW_READ,  16'h0001, 32'hFFFF_FFFF, 32'h1111_00A1};
        vecs[2] = '{RW_WRITE, 16'h0002, 32'h2222_00B2, 32'h1111_00A1};
        vecs[3] = '{RW_READ,  16'h0002, 32'hFFFF_FFFF, 32'h2222_00B2};
        vecs[4] = '{RW_WRITE, 16'h0003, 32'h3333_00C3, 32'h2222_00B2};
        vecs[5] = '{RW_READ,  16'h0003, 32'hFFFF_FFFF, 32'h3333_00C3};
        vecs[6] = '{RW_WRITE, 16'h0004, 32'h4444_00D4, 32'h3333_00C3};
        vecs[7] = '{RW_READ,  16'h0004, 32'hFFFF_FFFF, 32'h4444_00D4};
        vecs[8] = '{RW_WRITE, 16'h0005, 32'h5555_00E5, 32'h4444_00D4};
        vecs[9] = '{RW_READ,  16'h0005, 32'hFFFF_FFFF, 32'h5555_00E5};

        cpu_if.req_valid = 1'b0;
        cpu_if.req_rw    = 1'b0;
        cpu_if.req_addr  = '0;
        cpu_if.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // reset values
        chk("rst_req_ready", cpu_if.req_ready, 1);
        chk("rst_rsp_valid", cpu_if.rsp_valid, 0);
        chk("rst_rsp_rw",    cpu_if.rsp_rw, 0);
        chk("rst_rsp_rdata", cpu_if.rsp_rdata, 0);
        chk("rst_busy",      cpu_if.busy, 0);
        chk("rst_mc_valid",  mc_valid, 0);
        chk("rst_mc_rw",     mc_rw, 1);
        chk("rst_mc_addr",   mc_addr, 0);
`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        rst_n = 1'b1;
        tick();

        // single write, cycle-accurate against E0..E8
        push(RW_WRITE, 16'h0012, 32'hDEAD_BEEF);
        chk("wr_busy_after_push", cpu_if.busy, 1);
        chk("wr_valid_e0", mc_valid, 0);
        tick();
        chk("wr_valid_e1", mc_valid, 1);
        chk("wr_addr_e1",  mc_addr, 16'h0012);
        chk("wr_rw_e1",    mc_rw, 0);
        chk("wr_data_e1",  mc_data, 32'hDEAD_BEEF);
        tick();
        chk("wr_valid_e2", mc_valid, 0);
        chk("wr_data_e2",  mc_data, 32'hDEAD_BEEF);
        wait_rsp(n);
        chk("wr_rsp_cycles", n, 5);
        chk("wr_rsp_rw",     cpu_if.rsp_rw, 0);
        chk("wr_addr_held",  mc_addr, 16'h0012);
        tick();
        chk("wr_rsp_pulse",  cpu_if.rsp_valid, 0);
        chk("wr_ram",        ram[8'h12], 32'hDEAD_BEEF);

        // readback; junk wdata must not reach the bus
        push(RW_READ, 16'h0012, 32'h0BAD_F00D);
        wait_rsp(n);
        chk("rd_latency",    n, 7);
        chk("rd_rsp_rw",     cpu_if.rsp_rw, 1);
        chk("rd_rsp_rdata",  cpu_if.rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // alternating write/read table, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
            wait_rsp(n);
            chk($sformatf("vec%0d_latency", i), n, 7);
            chk($sformatf("vec%0d_rsp_rw", i),  cpu_if.rsp_rw, vecs[i].rw);
            chk($sformatf("vec%0d_rdata", i),   cpu_if.rsp_rdata, vecs[i].exp_rdata);
            if (vecs[i].rw == RW_WRITE)
                chk($sformatf("vec%0d_ram", i), ram[vecs[i].addr[7:0]], vecs[i].wdata);
        end
        chk("wrap_busy_in_done", cpu_if.busy, 1);
        tick();
        chk("wrap_busy_fall", cpu_if.busy, 0);

        // fill: one in flight, four queued -> full, fifth held; 3-cycle controller
        busy_len = 3;
        rb = rsp_n;
        lb = log_n;
        push(RW_WRITE, 16'h0020, 32'h0000_0020);
        tick();
        for (int k = 1; k <= 4; k++) begin
            push(RW_WRITE, AW'(16'h0020 + k), DW'(32'h0000_0020 + k));
        end
        chk("fill_full", cpu_if.req_ready, 0);
        push(RW_WRITE, 16'h0025, 32'h0000_0025);
        n = 0;
        while (rsp_n < rb + 6 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) bound_fail("fill_drain");
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fill_order%0d", k), log_addr[lb + k], 16'h0020 + k);
            chk($sformatf("fill_ram%0d", k), ram[8'h20 + k], 32'h0000_0020 + k);
        end
        for (int k = 1; k < 6; k++)
            chk($sformatf("fill_spacing%0d", k), rsp_cyc[rb + k] - rsp_cyc[rb + k - 1], 6);
        tick();
        tick();

        // reset in WAIT_HI with two requests queued
        busy_len = 4;
        rb = rsp_n;
        lb = log_n;
        push(RW_WRITE, 16'h0030, 32'h3030_3030);
        push(RW_WRITE, 16'h0031, 32'h3131_3131);
        push(RW_WRITE, 16'h0032, 32'h3232_3232);
        tick();
        chk("mid_in_wait_hi_ready", mc_ready, 0);
        chk("mid_data_driven", mc_data, 32'h3030_3030);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mc_valid",  mc_valid, 0);
        chk("mid_rst_mc_rw",     mc_rw, 1);
        chk("mid_rst_mc_addr",   mc_addr, 0);
        chk("mid_rst_req_ready", cpu_if.req_ready, 1);
        chk("mid_rst_busy",      cpu_if.busy, 0);
        chk("mid_rst_rsp_valid", cpu_if.rsp_valid, 0);
        chk("mid_rst_rsp_rdata", cpu_if.rsp_rdata, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("mid_no_rsp",     rsp_n, rb);
        chk("mid_no_reissue", log_n, lb + 1);
        chk("mid_busy_after", cpu_if.busy, 0);

`ifdef MEM_REQ_QUEUE_TIMEOUT_EN
        // controller never drops Ready: watchdog ends the request after 8 WAIT_LO cycles
        mc_hold = 1'b1;
        push(RW_READ, 16'h0040, 32'h0);
        wait_rsp(n);
        chk("to_latency",   n, 10);
        chk("to_rsp_rw",    cpu_if.rsp_rw, 1);
        chk("to_err_set",   timeout_err, 1);
        chk("to_rdata_kept", cpu_if.rsp_rdata, 0);
        repeat (5) tick();
        chk("to_err_sticky", timeout_err, 1);
        chk("to_busy_idle",  cpu_if.busy, 0);
        mc_hold = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
